// File: rtl/instr_fetch_unit.sv
// Fetch stage: holds the PC, fetches from a variable-latency instruction memory and presents the word
// to decode until it is accepted, then steps the PC using the control Branch/Jump outputs and ALU Zero.
module instr_fetch_unit #(
   parameter logic [31:0] RESET_PC      = 32'h0000_0000,
   parameter int          FETCH_TIMEOUT = 16
) (
   input  logic        CLK,
   input  logic        Reset,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_rdata,
   input  logic        imem_rvalid,
   output logic [31:0] Instruction,
   output logic [5:0]  Opcode,
   output logic [31:0] PCPlus4,
   output logic        InstrValid,
   input  logic        InstrAccept,
   input  logic        Branch,
   input  logic        Jump,
   input  logic        Zero,
   output logic        FetchError
);

   localparam int CW = $clog2(FETCH_TIMEOUT + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(FETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_ERR
   } state_t;

   state_t        state_q, state_d;
   logic [31:0]   pc_q, pc_d;
   logic [31:0]   instr_q, instr_d;
   logic [CW-1:0] cnt_q, cnt_d;

   logic [31:0]   pc_plus4;
   logic [31:0]   branch_off;
   logic [31:0]   next_pc;

   always_ff @(posedge CLK) begin
      if (Reset) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         cnt_q   <= cnt_d;
      end
   end

   assign pc_plus4   = pc_q + 32'd4;
   assign branch_off = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};

   // Jump has priority over a taken branch
   always_comb begin
      next_pc = pc_plus4;
      if (Jump) begin
         next_pc = {pc_plus4[31:28], instr_q[25:0], 2'b00};
      end else if (Branch && Zero) begin
         next_pc = pc_plus4 + branch_off;
      end
   end

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            cnt_d   = '0;
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (imem_rvalid) begin
               instr_d = imem_rdata;
               state_d = S_HOLD;
            end else begin
               cnt_d = cnt_q + CW'(1);
               if (cnt_q == CNT_LAST) begin
                  state_d = S_ERR;
               end
            end
         end
         S_HOLD: begin
            if (InstrAccept) begin
               pc_d    = next_pc;
               state_d = S_REQ;
            end
         end
         S_ERR:   state_d = S_ERR;
         default: state_d = S_IDLE;
      endcase
   end

   assign imem_req    = (state_q == S_REQ);
   assign imem_addr   = pc_q;
   assign Instruction = instr_q;
   assign Opcode      = instr_q[31:26];
   assign PCPlus4     = pc_plus4;
   assign InstrValid  = (state_q == S_HOLD);
   assign FetchError  = (state_q == S_ERR);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch transactions chained through PC updates, plus
// hand sequences for stall, timeout, reset-during-wait and a jump from a high PC on a second instance.
module tb_instr_fetch_unit;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        Reset;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic        imem_rvalid;
   logic [31:0] Instruction;
   logic [5:0]  Opcode;
   logic [31:0] PCPlus4;
   logic        InstrValid;
   logic        InstrAccept;
   logic        Branch, Jump, Zero;
   logic        FetchError;

   logic        hi_reset;
   logic        hi_req;
   logic [31:0] hi_addr;
   logic [31:0] hi_rdata;
   logic        hi_rvalid;
   logic [31:0] hi_instr;
   logic [5:0]  hi_opcode;
   logic [31:0] hi_pcp4;
   logic        hi_valid;
   logic        hi_accept;
   logic        hi_branch, hi_jump, hi_zero;
   logic        hi_err;

   instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FETCH_TIMEOUT(16)) dut (
      .CLK(clk), .Reset(Reset),
      .imem_req(imem_req), .imem_addr(imem_addr),
      .imem_rdata(imem_rdata), .imem_rvalid(imem_rvalid),
      .Instruction(Instruction), .Opcode(Opcode), .PCPlus4(PCPlus4),
      .InstrValid(InstrValid), .InstrAccept(InstrAccept),
      .Branch(Branch), .Jump(Jump), .Zero(Zero),
      .FetchError(FetchError)
   );

   instr_fetch_unit #(.RESET_PC(32'h4000_0008), .FETCH_TIMEOUT(16)) dut_hi (
      .CLK(clk), .Reset(hi_reset),
      .imem_req(hi_req), .imem_addr(hi_addr),
      .imem_rdata(hi_rdata), .imem_rvalid(hi_rvalid),
      .Instruction(hi_instr), .Opcode(hi_opcode), .PCPlus4(hi_pcp4),
      .InstrValid(hi_valid), .InstrAccept(hi_accept),
      .Branch(hi_branch), .Jump(hi_jump), .Zero(hi_zero),
      .FetchError(hi_err)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // Waits (bounded) at negedges until the main instance raises imem_req.
   task automatic wait_req(input int budget);
      for (int i = 0; i < budget; i++) begin
         if (imem_req === 1'b1) break;
         @(negedge clk);
      end
      chk("req_seen", {31'd0, imem_req}, 32'd1);
   endtask

   typedef struct {
      logic [31:0] word;
      int          lat;
      int          hold;
      logic        br;
      logic        jp;
      logic        zr;
      logic [31:0] exp_addr;
      logic [5:0]  exp_op;
      logic [31:0] exp_pcp4;
      logic [31:0] exp_next;
   } vec_t;

   vec_t vecs [8];

   task automatic do_reset();
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      chk("rst_req",   {31'd0, imem_req},   32'd0);
      chk("rst_valid", {31'd0, InstrValid}, 32'd0);
      chk("rst_err",   {31'd0, FetchError}, 32'd0);
      chk("rst_instr", Instruction,         32'd0);
      chk("rst_addr",  imem_addr,           32'd0);
      @(negedge clk);
      chk("first_req",  {31'd0, imem_req}, 32'd1);
      chk("first_addr", imem_addr,         32'd0);
      $display("reset: fetch restarts at %h", imem_addr);
   endtask

   initial begin
      Reset = 1'b1; imem_rdata = '0; imem_rvalid = 1'b0; InstrAccept = 1'b0;
      Branch = 1'b1; Jump = 1'b1; Zero = 1'b1;
      hi_reset = 1'b1; hi_rdata = '0; hi_rvalid = 1'b0; hi_accept = 1'b0;
      hi_branch = 1'b0; hi_jump = 1'b0; hi_zero = 1'b0;

      //            word          lat hold br    jp    zr    addr          op        pcp4          next
      vecs[0] = '{32'h8C22_0004, 2, 10, 1'b0, 1'b0, 1'b0, 32'h0000_0000, 6'b100011, 32'h0000_0004, 32'h0000_0004};
      vecs[1] = '{32'h0800_0004, 1, 0,  1'b0, 1'b1, 1'b0, 32'h0000_0004, 6'b000010, 32'h0000_0008, 32'h0000_0010};
      vecs[2] = '{32'h1000_FFFF, 3, 0,  1'b1, 1'b0, 1'b1, 32'h0000_0010, 6'b000100, 32'h0000_0014, 32'h0000_0010};
      vecs[3] = '{32'h1000_FFFF, 1, 0,  1'b1, 1'b0, 1'b0, 32'h0000_0010, 6'b000100, 32'h0000_0014, 32'h0000_0014};
      vecs[4] = '{32'h1000_8000, 2, 0,  1'b1, 1'b0, 1'b1, 32'h0000_0014, 6'b000100, 32'h0000_0018, 32'hFFFE_0018};
      vecs[5] = '{32'h0BFF_FFFF, 1, 0,  1'b1, 1'b1, 1'b1, 32'hFFFE_0018, 6'b000010, 32'hFFFE_001C, 32'hFFFF_FFFC};
      vecs[6] = '{32'h0000_0000, 1, 0,  1'b0, 1'b0, 1'b0, 32'hFFFF_FFFC, 6'b000000, 32'h0000_0000, 32'h0000_0000};
      vecs[7] = '{32'h1400_0003, 1, 3,  1'b1, 1'b0, 1'b1, 32'h0000_0000, 6'b000101, 32'h0000_0004, 32'h0000_0010};

      @(negedge clk);
      do_reset();

      // Chained fetches; Branch/Jump/Zero sit at 1 except on the accept cycle
      for (int v = 0; v < 8; v++) begin
         wait_req(10);
         chk($sformatf("v%0d_addr", v), imem_addr, vecs[v].exp_addr);
         repeat (vecs[v].lat) @(negedge clk);
         imem_rvalid = 1'b1;
         imem_rdata  = vecs[v].word;
         @(negedge clk);
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
         chk($sformatf("v%0d_valid", v), {31'd0, InstrValid}, 32'd1);
         chk($sformatf("v%0d_instr", v), Instruction, vecs[v].word);
         chk($sformatf("v%0d_op", v),    {26'd0, Opcode}, {26'd0, vecs[v].exp_op});
         chk($sformatf("v%0d_pcp4", v),  PCPlus4, vecs[v].exp_pcp4);
         chk($sformatf("v%0d_noreq", v), {31'd0, imem_req}, 32'd0);
         for (int h = 0; h < vecs[v].hold; h++) begin
            imem_rvalid = 1'b1;
            imem_rdata  = ~vecs[v].word;
            @(negedge clk);
            chk($sformatf("v%0d_hold_instr", v), Instruction, vecs[v].word);
            chk($sformatf("v%0d_hold_req", v),   {31'd0, imem_req}, 32'd0);
            chk($sformatf("v%0d_hold_valid", v), {31'd0, InstrValid}, 32'd1);
            chk($sformatf("v%0d_hold_addr", v),  imem_addr, vecs[v].exp_addr);
         end
         imem_rvalid = 1'b0;
         imem_rdata  = '0;
         Branch = vecs[v].br; Jump = vecs[v].jp; Zero = vecs[v].zr;
         InstrAccept = 1'b1;
         @(negedge clk);
         InstrAccept = 1'b0;
         Branch = 1'b1; Jump = 1'b1; Zero = 1'b1;
         chk($sformatf("v%0d_next_req", v),   {31'd0, imem_req}, 32'd1);
         chk($sformatf("v%0d_next_valid", v), {31'd0, InstrValid}, 32'd0);
         chk($sformatf("v%0d_next_addr", v),  imem_addr, vecs[v].exp_next);
         $display("fetch %0d: addr=%h word=%h B=%b J=%b Z=%b -> next=%h",
                  v, vecs[v].exp_addr, vecs[v].word, vecs[v].br, vecs[v].jp, vecs[v].zr, imem_addr);
      end

      // Timeout: request at 0x10 never answered
      wait_req(10);
      repeat (16) @(negedge clk);
      chk("tmo_err_before", {31'd0, FetchError}, 32'd0);
      @(negedge clk);
      chk("tmo_err_after", {31'd0, FetchError}, 32'd1);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h1234_5678;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("tmo_sticky", {31'd0, FetchError}, 32'd1);
         chk("tmo_noreq",  {31'd0, imem_req},   32'd0);
         chk("tmo_novalid", {31'd0, InstrValid}, 32'd0);
      end
      imem_rvalid = 1'b0;
      $display("timeout: FetchError=%b after 16 WAIT cycles", FetchError);
      do_reset();

      // Reset during WAIT, response arrives the cycle after reset
      @(negedge clk);
      Reset = 1'b1;
      @(negedge clk);
      Reset = 1'b0;
      imem_rvalid = 1'b1;
      imem_rdata  = 32'hDEAD_BEEF;
      chk("rw_valid0", {31'd0, InstrValid}, 32'd0);
      chk("rw_instr0", Instruction, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      chk("rw_req",    {31'd0, imem_req}, 32'd1);
      chk("rw_addr",   imem_addr, 32'd0);
      chk("rw_valid1", {31'd0, InstrValid}, 32'd0);
      chk("rw_instr1", Instruction, 32'd0);
      @(negedge clk);
      imem_rvalid = 1'b1;
      imem_rdata  = 32'h8C22_0004;
      @(negedge clk);
      imem_rvalid = 1'b0;
      chk("rw_refetch_valid", {31'd0, InstrValid}, 32'd1);
      chk("rw_refetch_instr", Instruction, 32'h8C22_0004);
      $display("reset-in-wait: late word dropped, refetch at 0 got %h", Instruction);

      // Jump from 0x4000_0008 with Branch and Zero also set
      hi_reset = 1'b0;
      @(negedge clk);
      chk("hi_req",  {31'd0, hi_req}, 32'd1);
      chk("hi_addr", hi_addr, 32'h4000_0008);
      @(negedge clk);
      hi_rvalid = 1'b1;
      hi_rdata  = 32'h0800_0100;
      @(negedge clk);
      hi_rvalid = 1'b0;
      chk("hi_valid", {31'd0, hi_valid}, 32'd1);
      chk("hi_op",    {26'd0, hi_opcode}, 32'd2);
      chk("hi_pcp4",  hi_pcp4, 32'h4000_000C);
      hi_branch = 1'b1; hi_jump = 1'b1; hi_zero = 1'b1;
      hi_accept = 1'b1;
      @(negedge clk);
      hi_accept = 1'b0;
      hi_branch = 1'b0; hi_jump = 1'b0; hi_zero = 1'b0;
      chk("hi_next_req",  {31'd0, hi_req}, 32'd1);
      chk("hi_next_addr", hi_addr, 32'h4000_0400);
      $display("high jump: 40000008 word 08000100 -> next=%h", hi_addr);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog expired");
   end

endmodule
